// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers.
// Intended to be reused by the transmitter (uart_tx_cfg) as well.
package uart_pkg;

    // Receiver frame states.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    // Smallest supported bit period; the 3-point vote needs room around the centre.
    localparam int unsigned MinClkDiv = 16;

    // Bit-centre count within one bit period.
    function automatic int unsigned bit_mid(input int unsigned clk_div);
        return clk_div / 2;
    endfunction

    // Width of a counter spanning one bit period (0 .. clk_div-1).
    function automatic int unsigned cnt_width(input int unsigned clk_div);
        return $clog2(clk_div);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver.
// Counts 0 .. CLK_DIV-1 and wraps; emits single-cycle strobes at the three
// majority-vote sample points around the bit centre.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   restart     hold the counter at zero (used while waiting for a start edge)
//   s_pre       counter == MID-1
//   s_mid       counter == MID
//   s_post      counter == MID+1
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic s_pre,
    output logic s_mid,
    output logic s_post
);

    localparam int unsigned CntW = cnt_width(CLK_DIV);
    localparam int unsigned Mid  = bit_mid(CLK_DIV);

    localparam logic [CntW-1:0] PreCnt  = CntW'(Mid - 1);
    localparam logic [CntW-1:0] MidCnt  = CntW'(Mid);
    localparam logic [CntW-1:0] PostCnt = CntW'(Mid + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            wrap;

    assign wrap = (cnt_q == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign s_pre  = (cnt_q == PreCnt);
    assign s_mid  = (cnt_q == MidCnt);
    assign s_post = (cnt_q == PostCnt);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with majority-vote sampling, false-start
// rejection, optional parity, 1/2 stop bits and framing/parity/overrun flags.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   RX           asynchronous serial input, idle high
//   clr_rx_rdy   consumer acknowledge; clears rx_rdy and ovr_err
//   rx_data      last received payload (LSB first on the line)
//   rx_rdy       a frame is available
//   frm_err      last frame had a low stop bit
//   par_err      last frame had a parity mismatch
//   ovr_err      sticky: a frame completed while rx_rdy was still set
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2604,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rx_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 frm_err,
    output logic                 par_err,
    output logic                 ovr_err
);

    localparam int unsigned    IdxW     = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
    localparam logic           LastStop = (STOP_BITS == 2);
    localparam logic           OddBit   = (PARITY_ODD != 0);
    localparam logic           HasPar   = (PARITY_EN != 0);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    logic rx_meta_q, rx_s_q, rx_q;
    logic fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_q      <= rx_s_q;
        end
    end

    // Requires a high-to-low transition, so a line stuck low never retriggers.
    assign fall = rx_q & ~rx_s_q;

    rx_state_t            state_q;
    logic [IdxW-1:0]      bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q;
    logic                 frm_bad_q;
    logic                 v_pre_q, v_mid_q;
    logic                 vote;
    logic                 s_pre, s_mid, s_post;

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_q == StIdle),
        .s_pre   (s_pre),
        .s_mid   (s_mid),
        .s_post  (s_post)
    );

    // Two earlier samples are stored; the third is the live value at MID+1.
    assign vote = (v_pre_q & v_mid_q) | (v_pre_q & rx_s_q) | (v_mid_q & rx_s_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            frm_bad_q  <= 1'b0;
            v_pre_q    <= 1'b1;
            v_mid_q    <= 1'b1;
            rx_data    <= '0;
            rx_rdy     <= 1'b0;
            frm_err    <= 1'b0;
            par_err    <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            if (s_pre) v_pre_q <= rx_s_q;
            if (s_mid) v_mid_q <= rx_s_q;

            // Acknowledge; a completion later in this block overrides rx_rdy.
            if (clr_rx_rdy) begin
                rx_rdy  <= 1'b0;
                ovr_err <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (fall) state_q <= StStart;
                end
                StStart: begin
                    if (s_post) begin
                        if (vote) begin
                            state_q <= StIdle;
                        end else begin
                            state_q    <= StData;
                            bit_idx_q  <= '0;
                            stop_idx_q <= 1'b0;
                            par_bad_q  <= 1'b0;
                            frm_bad_q  <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (s_post) begin
                        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LastIdx) begin
                            state_q <= HasPar ? StParity : StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + IdxW'(1);
                        end
                    end
                end
                StParity: begin
                    if (s_post) begin
                        par_bad_q <= (vote != ((^shift_q) ^ OddBit));
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (s_post) begin
                        if (stop_idx_q == LastStop) begin
                            // Complete at the last stop-bit vote, not the end of the
                            // bit, so an immediately following start edge is caught.
                            state_q <= StIdle;
                            rx_data <= shift_q;
                            frm_err <= frm_bad_q | ~vote;
                            par_err <= par_bad_q;
                            rx_rdy  <= 1'b1;
                            ovr_err <= clr_rx_rdy ? 1'b0 : (ovr_err | rx_rdy);
                        end else begin
                            frm_bad_q  <= frm_bad_q | ~vote;
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances cover 8N1, 8E1 and 9N2.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] rx_line;
    logic [2:0] clr_line;
    logic [7:0] data_a, data_b;
    logic [8:0] data_c;
    logic [2:0] rdy, frm, par, ovr;

    uart_rx_cfg #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .RX(rx_line[0]), .clr_rx_rdy(clr_line[0]),
           .rx_data(data_a), .rx_rdy(rdy[0]), .frm_err(frm[0]), .par_err(par[0]),
           .ovr_err(ovr[0]));

    uart_rx_cfg #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_b (.clk(clk), .rst_n(rst_n), .RX(rx_line[1]), .clr_rx_rdy(clr_line[1]),
           .rx_data(data_b), .rx_rdy(rdy[1]), .frm_err(frm[1]), .par_err(par[1]),
           .ovr_err(ovr[1]));

    uart_rx_cfg #(.CLK_DIV(64), .DATA_BITS(9), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut_c (.clk(clk), .rst_n(rst_n), .RX(rx_line[2]), .clr_rx_rdy(clr_line[2]),
           .rx_data(data_c), .rx_rdy(rdy[2]), .frm_err(frm[2]), .par_err(par[2]),
           .ovr_err(ovr[2]));

    typedef struct {
        logic [8:0] data;
        logic       frm;
        logic       par;
        logic       ovr;
        int         t;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   clr_tgt = -100;
    int   clr_dut = 0;
    logic [2:0] rdy_prev, ovr_prev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_div(input int d);  return (d == 2) ? 64 : 16; endfunction
    function automatic int cfg_db(input int d);   return (d == 2) ? 9 : 8;   endfunction
    function automatic int cfg_pe(input int d);   return (d == 1) ? 1 : 0;   endfunction
    function automatic int cfg_sb(input int d);   return (d == 2) ? 2 : 1;   endfunction

    function automatic logic [8:0] dout(input int d);
        case (d)
            0:       return {1'b0, data_a};
            1:       return {1'b0, data_b};
            default: return data_c;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: on every newly presented frame (rx_rdy rise or overrun rise) pop and compare.
    task automatic mon_step(input int d);
        exp_t e;
        int   n;
        bit   ev;
        ev = rst_n && ((rdy[d] && !rdy_prev[d]) || (ovr[d] && !ovr_prev[d]));
        rdy_prev[d] = rdy[d];
        ovr_prev[d] = ovr[d];
        if (ev) begin
            case (d)
                0:       begin n = q0.size(); if (n > 0) e = q0.pop_front(); end
                1:       begin n = q1.size(); if (n > 0) e = q1.pop_front(); end
                default: begin n = q2.size(); if (n > 0) e = q2.pop_front(); end
            endcase
            if (n == 0) begin
                total++;
                bad++;
                $display("FAIL dut%0d unexpected frame: data=0x%0h, expected no frame (cycle %0d)",
                         d, dout(d), cyc);
            end else begin
                chk($sformatf("dut%0d data", d), 32'(dout(d)), 32'(e.data));
                chk($sformatf("dut%0d frm_err", d), 32'(frm[d]), 32'(e.frm));
                chk($sformatf("dut%0d par_err", d), 32'(par[d]), 32'(e.par));
                chk($sformatf("dut%0d ovr_err", d), 32'(ovr[d]), 32'(e.ovr));
                total++;
                if (cyc < e.t - 1 || cyc > e.t + 1) begin
                    bad++;
                    $display("FAIL dut%0d latency: frame at cycle %0d, expected cycle %0d",
                             d, cyc, e.t);
                end
            end
        end
    endtask

    initial begin
        rdy_prev = '0;
        ovr_prev = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) mon_step(d);
        end
    end

    // One clock of stimulus; also drives a clear pulse aligned to a chosen completion edge.
    task automatic tick();
        @(negedge clk);
        if (cyc == clr_tgt - 1) clr_line[clr_dut] = 1'b1;
        else if (cyc == clr_tgt) clr_line[clr_dut] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic hold_bit(input int d, input logic lvl, input bit glitch);
        for (int k = 0; k < cfg_div(d); k++) begin
            rx_line[d] = (glitch && k == cfg_div(d) / 2) ? ~lvl : lvl;
            tick();
        end
    endtask

    // Drive one frame; the expected result follows directly from the frame contents.
    task automatic send(input int d, input logic [8:0] data, input logic par_bit,
                        input logic [1:0] stops, input bit glitch, input bit push,
                        input bit ovr_exp, input bit clr_on_done);
        exp_t       e;
        logic [8:0] dm;
        int         db, pe, sb, div;
        db  = cfg_db(d);
        pe  = cfg_pe(d);
        sb  = cfg_sb(d);
        div = cfg_div(d);
        dm  = (db == 9) ? data : (data & 9'h0FF);
        e.data = dm;
        e.par  = (pe != 0) && (par_bit != (^dm));
        e.frm  = (sb == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
        e.ovr  = ovr_exp;
        // Start edge at cycle cyc: 3 cycles of sync/edge detect, vote at MID+1 of the
        // last stop bit, result registered one cycle later.
        e.t    = cyc + (db + pe + sb) * div + div / 2 + 5;
        if (push) begin
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        if (clr_on_done) begin
            clr_tgt = e.t;
            clr_dut = d;
        end
        hold_bit(d, 1'b0, 1'b0);
        for (int i = 0; i < db; i++) hold_bit(d, dm[i], glitch);
        if (pe != 0) hold_bit(d, par_bit, 1'b0);
        for (int s = 0; s < sb; s++) hold_bit(d, stops[s], 1'b0);
        rx_line[d] = 1'b1;
        clr_tgt = -100;
    endtask

    task automatic consume(input int d);
        clr_line[d] = 1'b1;
        tick();
        clr_line[d] = 1'b0;
        chk($sformatf("dut%0d rx_rdy after clear", d), 32'(rdy[d]), 32'd0);
        chk($sformatf("dut%0d ovr_err after clear", d), 32'(ovr[d]), 32'd0);
    endtask

    task automatic check_zero(input int d, input string tag);
        chk($sformatf("%s dut%0d rx_data", tag, d), 32'(dout(d)), 32'd0);
        chk($sformatf("%s dut%0d rx_rdy", tag, d), 32'(rdy[d]), 32'd0);
        chk($sformatf("%s dut%0d frm_err", tag, d), 32'(frm[d]), 32'd0);
        chk($sformatf("%s dut%0d par_err", tag, d), 32'(par[d]), 32'd0);
        chk($sformatf("%s dut%0d ovr_err", tag, d), 32'(ovr[d]), 32'd0);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL watchdog: run still active at cycle %0d, expected completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [8:0] v;
        logic [1:0] st;
        logic       pb;
        bit         g;
        int         c0;

        rst_n    = 1'b0;
        rx_line  = 3'b111;
        clr_line = 3'b000;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) check_zero(d, "reset");
        idle(20);

        // Basic 8N1 frame.
        send(0, 9'h0A5, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(0);
        idle(16);

        // Short low pulse: rejected start, then a clean frame.
        rx_line[0] = 1'b0;
        idle(5);
        rx_line[0] = 1'b1;
        idle(40);
        send(0, 9'h03C, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(0);
        idle(16);

        // Even parity: 0x07 needs parity bit 1.
        send(1, 9'h007, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(1);
        idle(16);
        send(1, 9'h007, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(1);
        idle(16);

        // Back-to-back without acknowledge: second frame overruns.
        send(0, 9'h011, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 9'h022, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("overrun data", 32'(data_a), 32'h22);
        consume(0);
        idle(16);

        // Acknowledge on the completion edge: completion wins, no overrun.
        send(0, 9'h033, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(16);
        send(0, 9'h044, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("clr on completion rx_rdy", 32'(rdy[0]), 32'd1);
        chk("clr on completion ovr_err", 32'(ovr[0]), 32'd0);
        chk("clr on completion data", 32'(data_a), 32'h44);
        consume(0);
        idle(16);

        // Centre glitches are voted out; low stop bit flags a framing error.
        send(0, 9'h055, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(0);
        idle(16);
        send(0, 9'h055, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(0);
        idle(16);

        // Break for three frame times: exactly one 0x00 frame with framing error.
        begin
            exp_t e;
            e.data = 9'h000;
            e.frm  = 1'b1;
            e.par  = 1'b0;
            e.ovr  = 1'b0;
            e.t    = cyc + 9 * 16 + 8 + 5;
            q0.push_back(e);
        end
        rx_line[0] = 1'b0;
        idle(3 * 10 * 16);
        chk("break rx_rdy held", 32'(rdy[0]), 32'd1);
        rx_line[0] = 1'b1;
        idle(32);
        consume(0);
        idle(16);

        // Randomised traffic.
        for (int i = 0; i < 16; i++) begin
            v  = 9'($urandom_range(0, 255));
            g  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
            send(0, v, 1'b0, st, g, 1'b1, 1'b0, 1'b0);
            idle(4);
            consume(0);
            idle(16);
        end
        for (int i = 0; i < 16; i++) begin
            v  = 9'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            g  = 1'($urandom_range(0, 1));
            send(1, v, pb, 2'b11, g, 1'b1, 1'b0, 1'b0);
            idle(4);
            consume(1);
            idle(16);
        end

        // 9-bit, two stop bits.
        send(2, 9'h1FF, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(2);
        idle(64);
        for (int i = 0; i < 4; i++) begin
            v  = 9'($urandom_range(0, 511));
            c0 = $urandom_range(0, 2);
            st = (c0 == 0) ? 2'b11 : ((c0 == 1) ? 2'b10 : 2'b01);
            send(2, v, 1'b0, st, 1'b0, 1'b1, 1'b0, 1'b0);
            idle(4);
            consume(2);
            idle(64);
        end
        send(2, 9'h15A, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(70);

        // Reset in the middle of a frame (line high during data bits of 1s).
        hold_bit(2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hold_bit(2, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero(2, "mid-frame reset");
        chk("mid-frame reset dut0 rx_rdy", 32'(rdy[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        idle(2 * 64);
        chk("partial frame discarded", 32'(rdy[2]), 32'd0);
        send(2, 9'h0AA, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        consume(2);
        idle(64);

        chk("dut0 frames pending", 32'(q0.size()), 32'd0);
        chk("dut1 frames pending", 32'(q1.size()), 32'd0);
        chk("dut2 frames pending", 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
